// File: rtl/vend_pkg.sv
// vend_pkg: shared types and constants for the vending transaction sequencer.
//   state_e  - controller FSM encoding
//   entry_t  - one stock/price table entry
//   calc_cost - count*price at full product width
package vend_pkg;
  localparam int NUM_PRODUCTS = 4;
  localparam int CODE_W       = 2;
  localparam int CNT_W        = 3;
  localparam int PRICE_W      = 3;
  localparam int COST_W       = CNT_W + PRICE_W;  // 7*7 = 49 fits in 6 bits

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CREDIT   = 3'd1,
    CHECK    = 3'd2,
    DISPENSE = 3'd3,
    CHANGE   = 3'd4
  } state_e;

  typedef struct packed {
    logic [CNT_W-1:0]   stock;
    logic [PRICE_W-1:0] price;
  } entry_t;

  function automatic logic [COST_W-1:0] calc_cost(input logic [CNT_W-1:0]   cnt,
                                                  input logic [PRICE_W-1:0] price);
    return COST_W'(cnt) * COST_W'(price);
  endfunction
endpackage

// File: rtl/vend_stock_table.sv
// vend_stock_table: NUM_PRODUCTS x {stock, price} register file.
//   clk, rst_n                       clock / async active-low reset (clears table)
//   rd_code -> rd_stock, rd_price    asynchronous read port
//   wr_en, wr_code, wr_stock, wr_price  configuration write
//   dec_en, dec_code, dec_count      stock decrement after a dispense
// Decrement wins over write; the controller never issues both together.
module vend_stock_table
  import vend_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CODE_W-1:0]  rd_code,
  output logic [CNT_W-1:0]   rd_stock,
  output logic [PRICE_W-1:0] rd_price,
  input  logic               wr_en,
  input  logic [CODE_W-1:0]  wr_code,
  input  logic [CNT_W-1:0]   wr_stock,
  input  logic [PRICE_W-1:0] wr_price,
  input  logic               dec_en,
  input  logic [CODE_W-1:0]  dec_code,
  input  logic [CNT_W-1:0]   dec_count
);
  entry_t [NUM_PRODUCTS-1:0] tbl_q;

  for (genvar i = 0; i < NUM_PRODUCTS; i++) begin : g_ent
    entry_t ent_q, ent_d;

    always_comb begin
      ent_d = ent_q;
      if (dec_en && dec_code == CODE_W'(i))
        ent_d.stock = ent_q.stock - dec_count;
      else if (wr_en && wr_code == CODE_W'(i))
        ent_d = '{stock: wr_stock, price: wr_price};
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ent_q <= '0;
      else        ent_q <= ent_d;
    end

    assign tbl_q[i] = ent_q;
  end

  assign rd_stock = tbl_q[rd_code].stock;
  assign rd_price = tbl_q[rd_code].price;
endmodule

// File: rtl/vend_controller.sv
// vend_controller: transaction sequencer for the 4-product vending datapath.
//   clk, rst_n                     clock / async active-low reset
//   coin_valid, coin_value         coin strobe (value 0 is not a coin)
//   sel_valid, sel_code, sel_count selection strobe
//   cancel                         refund request (CREDIT only)
//   cfg_we, cfg_code, cfg_stock, cfg_price  table write (IDLE only)
//   disp_req, disp_code, disp_count, disp_ack  dispense handshake
//   change_valid, change_amt       one-cycle change/refund pulse
//   credit                         current credit
//   coin_reject, sel_error         one-cycle rejection pulses
//   busy                           high in CHECK, DISPENSE, CHANGE
// Every output is a flop loaded from the next-state values, so outputs
// line up with the state they describe.
module vend_controller
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 6,
  parameter int TIMEOUT  = 255,
  parameter int TMO_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_valid,
  input  logic [3:0]          coin_value,
  input  logic                sel_valid,
  input  logic [1:0]          sel_code,
  input  logic [2:0]          sel_count,
  input  logic                cancel,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_code,
  input  logic [2:0]          cfg_stock,
  input  logic [2:0]          cfg_price,
  output logic                disp_req,
  output logic [1:0]          disp_code,
  output logic [2:0]          disp_count,
  input  logic                disp_ack,
  output logic                change_valid,
  output logic [CREDIT_W-1:0] change_amt,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                sel_error,
  output logic                busy
);
  localparam int XW = CREDIT_W + COST_W;  // common width for credit/cost compare

  state_e state_q, state_d;

  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] cost_q, cost_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [CODE_W-1:0]   sel_code_q, sel_code_d;
  logic [CNT_W-1:0]    sel_cnt_q, sel_cnt_d;

  logic                disp_req_q, disp_req_d;
  logic [CODE_W-1:0]   disp_code_q, disp_code_d;
  logic [CNT_W-1:0]    disp_count_q, disp_count_d;
  logic                change_valid_q, change_valid_d;
  logic [CREDIT_W-1:0] change_amt_q, change_amt_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sel_error_q, sel_error_d;
  logic                busy_q, busy_d;

  logic                coin_ev, coin_fits, coin_rej, sel_err;
  logic                cfg_wr, dec_en, check_ok;
  logic [CREDIT_W:0]   coin_sum;
  logic [COST_W-1:0]   cost_full;
  logic [CNT_W-1:0]    tbl_stock;
  logic [PRICE_W-1:0]  tbl_price;

  vend_stock_table u_tbl (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_code   (sel_code_q),
    .rd_stock  (tbl_stock),
    .rd_price  (tbl_price),
    .wr_en     (cfg_wr),
    .wr_code   (cfg_code),
    .wr_stock  (cfg_stock),
    .wr_price  (cfg_price),
    .dec_en    (dec_en),
    .dec_code  (sel_code_q),
    .dec_count (sel_cnt_q)
  );

  // Coin arithmetic one bit wider so overflow past the credit ceiling shows
  // up in the carry.
  assign coin_ev   = coin_valid && (coin_value != 4'd0);
  assign coin_sum  = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value);
  assign coin_fits = !coin_sum[CREDIT_W];

  assign cost_full = calc_cost(sel_cnt_q, tbl_price);
  assign check_ok  = (sel_cnt_q != '0) && (sel_cnt_q <= tbl_stock) &&
                     (XW'(credit_q) >= XW'(cost_full));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and datapath
  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    cost_d     = cost_q;
    tmo_d      = tmo_q;
    sel_code_d = sel_code_q;
    sel_cnt_d  = sel_cnt_q;
    coin_rej   = 1'b0;
    sel_err    = 1'b0;
    cfg_wr     = 1'b0;
    dec_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cfg_wr = cfg_we;
        tmo_d  = '0;
        sel_err = sel_valid;
        if (coin_ev) begin
          if (coin_fits) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = CREDIT;
          end else begin
            coin_rej = 1'b1;
          end
        end
      end
      CREDIT: begin
        // cancel > sel_valid > coin; a coin losing arbitration is rejected
        if (cancel) begin
          coin_rej = coin_ev;
          state_d  = CHANGE;
        end else if (sel_valid) begin
          coin_rej   = coin_ev;
          sel_code_d = sel_code;
          sel_cnt_d  = sel_count;
          state_d    = CHECK;
        end else if (coin_ev && coin_fits) begin
          credit_d = coin_sum[CREDIT_W-1:0];
          tmo_d    = '0;
        end else begin
          coin_rej = coin_ev;
          if (tmo_q == TMO_W'(TIMEOUT - 1)) state_d = CHANGE;
          else                              tmo_d   = tmo_q + 1'b1;
        end
      end
      CHECK: begin
        coin_rej = coin_ev;
        if (check_ok) begin
          // A passing check implies cost <= credit, so the narrowing is lossless.
          cost_d  = CREDIT_W'(cost_full);
          state_d = DISPENSE;
        end else begin
          sel_err = 1'b1;
          tmo_d   = '0;
          state_d = CREDIT;
        end
      end
      DISPENSE: begin
        coin_rej = coin_ev;
        if (disp_ack) begin
          dec_en   = 1'b1;
          credit_d = credit_q - cost_q;
          state_d  = CHANGE;
        end
      end
      CHANGE: begin
        coin_rej = coin_ev;
        credit_d = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next values, decoded from the state being entered
  always_comb begin
    disp_req_d     = (state_d == DISPENSE);
    disp_code_d    = disp_req_d ? sel_code_d : '0;
    disp_count_d   = disp_req_d ? sel_cnt_d  : '0;
    change_valid_d = (state_d == CHANGE);
    change_amt_d   = change_valid_d ? credit_d : '0;
    coin_reject_d  = coin_rej;
    sel_error_d    = sel_err;
    busy_d         = (state_d == CHECK) || (state_d == DISPENSE) || (state_d == CHANGE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q       <= '0;
      cost_q         <= '0;
      tmo_q          <= '0;
      sel_code_q     <= '0;
      sel_cnt_q      <= '0;
      disp_req_q     <= 1'b0;
      disp_code_q    <= '0;
      disp_count_q   <= '0;
      change_valid_q <= 1'b0;
      change_amt_q   <= '0;
      coin_reject_q  <= 1'b0;
      sel_error_q    <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      credit_q       <= credit_d;
      cost_q         <= cost_d;
      tmo_q          <= tmo_d;
      sel_code_q     <= sel_code_d;
      sel_cnt_q      <= sel_cnt_d;
      disp_req_q     <= disp_req_d;
      disp_code_q    <= disp_code_d;
      disp_count_q   <= disp_count_d;
      change_valid_q <= change_valid_d;
      change_amt_q   <= change_amt_d;
      coin_reject_q  <= coin_reject_d;
      sel_error_q    <= sel_error_d;
      busy_q         <= busy_d;
    end
  end

  assign credit       = credit_q;
  assign disp_req     = disp_req_q;
  assign disp_code    = disp_code_q;
  assign disp_count   = disp_count_q;
  assign change_valid = change_valid_q;
  assign change_amt   = change_amt_q;
  assign coin_reject  = coin_reject_q;
  assign sel_error    = sel_error_q;
  assign busy         = busy_q;
endmodule
